// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the EX/MEM stage and data_mem.
// Requests are validated before any memory strobe; load data is formatted on capture.
module mem_access_unit #(
    parameter logic [31:0] DATA_MEM_BYTES = 32'h0000_3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_OP    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_word_op(input logic [2:0] op);
        is_word_op = (op == OP_LW) || (op == OP_SW);
    endfunction

    // data_mem ORs store data into the word, so byte stores must carry zero upper bits
    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
        case (op)
            OP_SW:   store_data = wdata;
            OP_SB:   store_data = {24'h00_0000, wdata[7:0]};
            default: store_data = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] op, input logic [31:0] rdata);
        case (op)
            OP_LW:   load_format = rdata;
            OP_LB:   load_format = {{24{rdata[7]}}, rdata[7:0]};
            OP_LBU:  load_format = {24'h00_0000, rdata[7:0]};
            default: load_format = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  fault_s;
    logic [2:0]  op_r;
    logic [31:0] resp_data_r;
    logic [4:0]  resp_rd_r;
    logic [1:0]  resp_fault_r;
    logic [31:0] mem_addr_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        mem_byte_en_r;
    logic [31:0] mem_wdata_r;

    // Request check with priority: illegal op, then range, then word alignment
    always_comb begin
        fault_s = FAULT_NONE;
        if (!is_legal_op(req_op)) begin
            fault_s = FAULT_OP;
        end else if (req_addr >= DATA_MEM_BYTES) begin
            fault_s = FAULT_RANGE;
        end else if (is_word_op(req_op) && (req_addr[1:0] != 2'b00)) begin
            fault_s = FAULT_ALIGN;
        end else begin
            fault_s = FAULT_NONE;
        end
    end

    // Next-state logic; faulting requests skip ACCESS entirely
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (fault_s != FAULT_NONE) state_next_s = RESP;
                    else                       state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP: begin
                if (resp_ready) state_next_s = IDLE;
                else            state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Strobes are loaded on accept so they are live for exactly the ACCESS cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r          <= 3'b000;
            resp_data_r   <= 32'h0000_0000;
            resp_rd_r     <= 5'd0;
            resp_fault_r  <= FAULT_NONE;
            mem_addr_r    <= 32'h0000_0000;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_byte_en_r <= 1'b0;
            mem_wdata_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r         <= req_op;
                        resp_rd_r    <= req_rd;
                        resp_fault_r <= fault_s;
                        resp_data_r  <= 32'h0000_0000;
                        if (fault_s == FAULT_NONE) begin
                            mem_addr_r    <= req_addr;
                            mem_read_r    <= ~req_op[2];
                            mem_write_r   <= req_op[2];
                            mem_byte_en_r <= ~is_word_op(req_op);
                            mem_wdata_r   <= store_data(req_op, req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    resp_data_r   <= load_format(op_r, mem_rdata);
                    mem_addr_r    <= 32'h0000_0000;
                    mem_read_r    <= 1'b0;
                    mem_write_r   <= 1'b0;
                    mem_byte_en_r <= 1'b0;
                    mem_wdata_r   <= 32'h0000_0000;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_data_r  <= 32'h0000_0000;
                        resp_rd_r    <= 5'd0;
                        resp_fault_r <= FAULT_NONE;
                    end
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (state_r == IDLE) & reset;
    assign resp_valid  = (state_r == RESP);
    assign resp_data   = resp_data_r;
    assign resp_rd     = resp_rd_r;
    assign resp_fault  = resp_fault_r;
    assign mem_addr    = mem_addr_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_byte_en = mem_byte_en_r;
    assign mem_wdata   = mem_wdata_r;

endmodule
